instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch sequencer for the 16-bit processor. It walks a program counter through synchronous program memory and presents one instruction word at a time to the core over a valid/ack handshake, in place of a bench that holds each word manually. The end-of-program word 0x0000 stops fetching. The block sits between program ROM/BRAM and the core's `instruction` input.

## Interface
- `ADDR_W`, 16: program-memory address width; the PC wraps modulo 2^ADDR_W.
- `START_ADDR`, 0: PC value after reset and on each `start`.
- `HALT_WORD`, 16'h0000: end-of-program instruction word.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin fetching at START_ADDR; sampled in IDLE and HALT only.
- `mem_en`  out  1  program-memory read enable.
- `mem_addr`  out  ADDR_W  program-memory read address.
- `mem_rdata`  in  16  read data, valid the cycle after `mem_en`=1 (1-cycle latency).
- `instr`  out  16  instruction presented to the core.
- `instr_valid`  out  1  `instr` is valid and held stable until acked.
- `instr_ack`  in  1  core has finished the presented instruction.
- `redirect`  in  1  take `redirect_pc` as the next PC; qualified by ack.
- `redirect_pc`  in  ADDR_W  branch/jump target.
- `pc`  out  ADDR_W  address of the word currently fetched or presented.
- `halted`  out  1  HALT_WORD fetched; fetching stopped.

## Operation
- FSM states:
  - IDLE (reset state): `start` → FETCH, and `pc` ← START_ADDR.
  - FETCH: `mem_en`=1, `mem_addr`=`pc`; → LATCH.
  - LATCH: capture `mem_rdata`. If the word equals HALT_WORD → HALT. Otherwise load `instr` → ISSUE.
  - ISSUE: `instr_valid`=1. On `instr_ack`=1 → FETCH, and `pc` ← `redirect` ? `redirect_pc` : `pc`+1.
  - HALT: `halted`=1; `start` → FETCH with `pc` ← START_ADDR.
- Arithmetic and handshake rules:
  - `pc`+1 is an ADDR_W-bit add; all-ones wraps to 0 with no flag.
  - HALT_WORD is never presented: `instr_valid` stays 0 and `instr` keeps the previous word.
  - `redirect` and `redirect_pc` are ignored unless `instr_ack`=1 in ISSUE.
  - `instr_ack` outside ISSUE is ignored.
  - `start` in FETCH, LATCH or ISSUE is ignored.
  - `instr` and `pc` do not change while `instr_valid`=1.
- Reset: `rst`=1 in any state, including mid-handshake, forces IDLE on the next edge. Reset values:
  - `pc` = START_ADDR
  - `instr` = 16'h0000
  - `instr_valid`, `mem_en`, `halted` = 0
  - `mem_addr` = START_ADDR

## Timing
- `mem_en` and `mem_addr` are combinational from the state and `pc` registers. `instr`, `instr_valid`, `pc` and `halted` are registered.
- Cycle of `start` = T. FETCH at T+1, LATCH at T+2, `instr_valid`=1 at T+3.
- Ack at cycle A → `instr_valid`=0 at A+1 (FETCH) → next `instr_valid`=1 at A+3. The minimum issue interval is 3 cycles plus core latency.
- If `instr_ack` is held high continuously, exactly one instruction is consumed per ISSUE entry.
- HALT_WORD in LATCH at cycle L → `halted`=1 at L+1. `pc` keeps the address of the halt word.

## Structure
- Shared package `proc_pkg`:
  - state encoding `fetch_state_t` (IDLE, FETCH, LATCH, ISSUE, HALT)
  - constants HALT_WORD and START_ADDR defaults
  - opcode constants shared with the decoder
- One natural sub-module, `if_pc_counter`: PC register with load (start/redirect), increment and wrap.
- The FSM and instruction register stay in `instr_fetch`.

## Test plan
- Sequence: memory[0..3] = 0x4142, 0x4402, 0x0253, 0x0000; pulse `start`; ack each word 5 cycles after valid.
  - Required: `instr` = 0x4142, then 0x4402, then 0x0253, each first valid 3 cycles after the previous ack.
  - Required: `halted`=1 two cycles after FETCH of address 3, with `pc`=3 and no fourth valid.
- Redirect: memory[0]=0x0291, memory[8]=0x0253; ack word 0 with `redirect`=1, `redirect_pc`=8.
  - Required: next `mem_addr`=8 and `instr`=0x0253. `redirect`=1 without ack changes nothing.
- Wrap: START_ADDR = 2^ADDR_W−1 (ADDR_W=4, so 15), memory[15]=0x0253, memory[0]=0x0291.
  - Required: `pc` goes 15 → 0 and `instr`=0x0291 follows.
- Reset mid-ISSUE: assert `rst` while `instr_valid`=1 with `instr_ack`=1.
  - Required: next cycle `instr_valid`=0, `pc`=START_ADDR, state IDLE, `instr`=0x0000, no PC increment.
- Restart and stray inputs:
  - From HALT, pulse `start` → refetch from START_ADDR with `halted`=0 at the next cycle.
  - `start` pulses during ISSUE → ignored; `instr` and `pc` stay stable.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor front end.
//   fetch_state_t    : instruction-fetch sequencer states
//   PROC_HALT_WORD   : default end-of-program instruction word
//   PROC_START_ADDR  : default program start address
//   OP_*             : opcode field values shared with the decoder
//   opcode_of()      : extracts the opcode field of an instruction word
package proc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_HALT
  } fetch_state_t;

  localparam logic [15:0] PROC_HALT_WORD  = 16'h0000;
  localparam int unsigned PROC_START_ADDR = 0;

  localparam logic [3:0] OP_ALU    = 4'h0;
  localparam logic [3:0] OP_LOADI  = 4'h4;
  localparam logic [3:0] OP_BRANCH = 4'h8;
  localparam logic [3:0] OP_JUMP   = 4'hC;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[15:12];
  endfunction

endpackage

// File: rtl/if_pc_counter.sv
// Program counter for the fetch sequencer.
//   clk, rst    : clock, synchronous active-high reset (pc <- START_ADDR)
//   i_load      : load i_load_val (start / redirect); has priority over i_inc
//   i_load_val  : value to load
//   i_inc       : advance pc by one, wrapping modulo 2^ADDR_W
//   o_pc        : current pc
module if_pc_counter #(
  parameter int unsigned        ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= START_ADDR;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: walks the PC through synchronous program
// memory (1-cycle read latency) and presents one word at a time to the core
// over a valid/ack handshake. The HALT_WORD stops fetching until start.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin fetching at START_ADDR (IDLE/HALT only)
//   mem_en, mem_addr  : program-memory read request (combinational)
//   mem_rdata         : read data, valid the cycle after mem_en
//   instr, instr_valid: presented instruction, held until instr_ack
//   instr_ack         : core consumed the presented instruction
//   redirect, redirect_pc : next-PC override, qualified by the ack
//   pc                : address of the word fetched / presented
//   halted            : HALT_WORD fetched, fetching stopped
module instr_fetch
  import proc_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]  START_ADDR = ADDR_W'(PROC_START_ADDR),
  parameter logic [15:0]        HALT_WORD  = PROC_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_t      r_state;
  fetch_state_t      w_next;
  logic [15:0]       r_instr;
  logic              r_instr_valid;
  logic              r_halted;
  logic              w_pc_load;
  logic [ADDR_W-1:0] w_pc_load_val;
  logic              w_pc_inc;
  logic              w_mem_en;
  logic              w_is_halt;
  logic [ADDR_W-1:0] w_pc;

  assign w_is_halt = (mem_rdata == HALT_WORD);

  always_comb begin
    w_next        = r_state;
    w_pc_load     = 1'b0;
    w_pc_load_val = START_ADDR;
    w_pc_inc      = 1'b0;
    w_mem_en      = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          w_next    = ST_FETCH;
          w_pc_load = 1'b1;
        end
      end
      ST_FETCH: begin
        w_mem_en = 1'b1;
        w_next   = ST_LATCH;
      end
      ST_LATCH: begin
        w_next = w_is_halt ? ST_HALT : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (instr_ack) begin
          w_next = ST_FETCH;
          if (redirect) begin
            w_pc_load     = 1'b1;
            w_pc_load_val = redirect_pc;
          end else begin
            w_pc_inc = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Valid/halted are registered from the next state so they line up
  // exactly with the ISSUE/HALT state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_instr_valid <= (w_next == ST_ISSUE);
      r_halted      <= (w_next == ST_HALT);
      // The halt word is never loaded, so instr keeps the previous word.
      if (r_state == ST_LATCH && !w_is_halt) begin
        r_instr <= mem_rdata;
      end
    end
  end

  if_pc_counter #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_pc_load),
    .i_load_val (w_pc_load_val),
    .i_inc      (w_pc_inc),
    .o_pc       (w_pc)
  );

  assign mem_en      = w_mem_en;
  assign mem_addr    = w_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = w_pc;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 8-bit address space, START_ADDR = 0
  logic        a_rst, a_start, a_ack, a_redir;
  logic [7:0]  a_rpc;
  logic        a_mem_en;
  logic [7:0]  a_mem_addr;
  logic [15:0] a_rdata;
  logic [15:0] a_instr;
  logic        a_valid, a_halted;
  logic [7:0]  a_pc;
  logic [15:0] mem_a [256];

  // DUT B: 4-bit address space, START_ADDR = 15 (wrap case)
  logic        b_rst, b_start, b_ack, b_redir;
  logic [3:0]  b_rpc;
  logic        b_mem_en;
  logic [3:0]  b_mem_addr;
  logic [15:0] b_rdata;
  logic [15:0] b_instr;
  logic        b_valid, b_halted;
  logic [3:0]  b_pc;
  logic [15:0] mem_b [16];

  instr_fetch #(.ADDR_W(8), .START_ADDR(8'h00), .HALT_WORD(16'h0000)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start),
    .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_rdata(a_rdata),
    .instr(a_instr), .instr_valid(a_valid), .instr_ack(a_ack),
    .redirect(a_redir), .redirect_pc(a_rpc), .pc(a_pc), .halted(a_halted)
  );

  instr_fetch #(.ADDR_W(4), .START_ADDR(4'hF), .HALT_WORD(16'h0000)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_rdata(b_rdata),
    .instr(b_instr), .instr_valid(b_valid), .instr_ack(b_ack),
    .redirect(b_redir), .redirect_pc(b_rpc), .pc(b_pc), .halted(b_halted)
  );

  // Synchronous program memories, 1-cycle read latency
  always @(posedge clk) if (a_mem_en) a_rdata <= mem_a[a_mem_addr];
  always @(posedge clk) if (b_mem_en) b_rdata <= mem_b[b_mem_addr];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until DUT A shows valid or halted; n = cycles from the launch
  // cycle (start or ack) to that event. Optional random noise on inputs
  // that must be ignored outside ISSUE/IDLE/HALT.
  task automatic wait_valid(input bit hold_ack, input bit noise, output int n);
    n = 0;
    do begin
      tick();
      n++;
      a_ack   = hold_ack;
      a_start = noise ? 1'($urandom) : 1'b0;
      a_redir = noise ? 1'($urandom) : 1'b0;
      a_rpc   = noise ? 8'($urandom) : 8'h00;
    end while (!a_valid && !a_halted && n < 20);
    a_start = 1'b0;
    if (n >= 20) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_valid: no valid/halted within 20 cycles (t=%0t)", $time);
    end
  endtask

  typedef struct {
    logic        redir;
    logic [7:0]  target;
    logic [7:0]  exp_pc;
    logic [15:0] exp_instr;
    logic        exp_halt;
  } vec_t;

  vec_t        tbl [6];
  logic [15:0] seq [3];
  int          n;
  int          d;
  logic [7:0]  exp_pc;
  logic [15:0] last_w;
  logic [15:0] w;
  logic        r;
  logic [7:0]  tgt;

  task automatic fill_random();
    for (int i = 0; i < 256; i++)
      mem_a[i] = ($urandom % 8 == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
  endtask

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_ack = 1'b0; a_redir = 1'b0; a_rpc = '0;
    b_rst = 1'b1; b_start = 1'b0; b_ack = 1'b0; b_redir = 1'b0; b_rpc = '0;
    a_rdata = '0; b_rdata = '0;
    for (int i = 0; i < 256; i++) mem_a[i] = 16'h0000;
    for (int i = 0; i < 16; i++)  mem_b[i] = 16'h0000;

    tbl[0] = '{1'b0, 8'h00, 8'h01, 16'hA501, 1'b0};
    tbl[1] = '{1'b1, 8'h40, 8'h40, 16'hA540, 1'b0};
    tbl[2] = '{1'b0, 8'h77, 8'h41, 16'hA541, 1'b0};
    tbl[3] = '{1'b1, 8'hFF, 8'hFF, 16'hA5FF, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 8'h00, 16'hA500, 1'b0};
    tbl[5] = '{1'b1, 8'h20, 8'h20, 16'hA500, 1'b1};
    seq[0] = 16'h4142; seq[1] = 16'h4402; seq[2] = 16'h0253;

    // ---- reset state ----
    tick(); tick();
    a_rst = 1'b0;
    chk("rst valid",    32'(a_valid),    32'd0);
    chk("rst halted",   32'(a_halted),   32'd0);
    chk("rst mem_en",   32'(a_mem_en),   32'd0);
    chk("rst pc",       32'(a_pc),       32'h00);
    chk("rst mem_addr", 32'(a_mem_addr), 32'h00);
    chk("rst instr",    32'(a_instr),    32'h0000);

    // ---- basic program with halt word ----
    mem_a[0] = 16'h4142; mem_a[1] = 16'h4402; mem_a[2] = 16'h0253; mem_a[3] = 16'h0000;
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("seq fetch mem_en", 32'(a_mem_en), 32'd1);
    chk("seq fetch addr",   32'(a_mem_addr), 32'h00);
    tick(); tick();
    chk("seq first valid", 32'(a_valid), 32'd1);
    chk("seq first instr", 32'(a_instr), 32'h4142);
    chk("seq first pc",    32'(a_pc),    32'h00);
    for (int k = 0; k < 3; k++) begin
      repeat (5) tick();
      chk("seq held valid", 32'(a_valid), 32'd1);
      chk("seq held instr", 32'(a_instr), 32'(seq[k]));
      a_ack = 1'b1; tick(); a_ack = 1'b0;
      chk("seq ack valid drop", 32'(a_valid),    32'd0);
      chk("seq next mem_en",    32'(a_mem_en),   32'd1);
      chk("seq next addr",      32'(a_mem_addr), 32'(k + 1));
      tick(); tick();
      if (k < 2) begin
        chk("seq valid", 32'(a_valid), 32'd1);
        chk("seq instr", 32'(a_instr), 32'(seq[k+1]));
        chk("seq pc",    32'(a_pc),    32'(k + 1));
      end else begin
        chk("seq halted",       32'(a_halted), 32'd1);
        chk("seq halt pc",      32'(a_pc),     32'h03);
        chk("seq halt valid",   32'(a_valid),  32'd0);
        chk("seq halt instr",   32'(a_instr),  32'h0253);
      end
    end
    repeat (3) tick();
    chk("halt stays valid0", 32'(a_valid),  32'd0);
    chk("halt stays",        32'(a_halted), 32'd1);

    // ---- restart from HALT ----
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("restart halted", 32'(a_halted),   32'd0);
    chk("restart pc",     32'(a_pc),       32'h00);
    chk("restart addr",   32'(a_mem_addr), 32'h00);
    tick(); tick();
    chk("restart valid", 32'(a_valid), 32'd1);
    chk("restart instr", 32'(a_instr), 32'h4142);

    // ---- stray start / redirect without ack during ISSUE ----
    a_start = 1'b1; a_redir = 1'b1; a_rpc = 8'h08;
    repeat (3) tick();
    a_start = 1'b0; a_redir = 1'b0;
    chk("stray valid", 32'(a_valid), 32'd1);
    chk("stray instr", 32'(a_instr), 32'h4142);
    chk("stray pc",    32'(a_pc),    32'h00);

    // ---- reset mid-ISSUE with ack high ----
    a_rst = 1'b1; a_ack = 1'b1; tick(); a_rst = 1'b0; a_ack = 1'b0;
    chk("midrst valid",  32'(a_valid),  32'd0);
    chk("midrst pc",     32'(a_pc),     32'h00);
    chk("midrst instr",  32'(a_instr),  32'h0000);
    chk("midrst mem_en", 32'(a_mem_en), 32'd0);
    tick();
    chk("midrst idle mem_en", 32'(a_mem_en), 32'd0);
    chk("midrst idle pc",     32'(a_pc),     32'h00);

    // ---- redirect ----
    mem_a[0] = 16'h0291; mem_a[8] = 16'h0253;
    a_start = 1'b1; tick(); a_start = 1'b0; tick(); tick();
    chk("redir first instr", 32'(a_instr), 32'h0291);
    a_ack = 1'b1; a_redir = 1'b1; a_rpc = 8'h08; tick();
    a_ack = 1'b0; a_redir = 1'b0; a_rpc = 8'h00;
    chk("redir mem_addr", 32'(a_mem_addr), 32'h08);
    tick(); tick();
    chk("redir valid", 32'(a_valid), 32'd1);
    chk("redir instr", 32'(a_instr), 32'h0253);
    chk("redir pc",    32'(a_pc),    32'h08);

    // ---- wrap on DUT B ----
    mem_b[15] = 16'h0253; mem_b[0] = 16'h0291;
    tick(); b_rst = 1'b0;
    chk("wrap rst pc", 32'(b_pc), 32'hF);
    b_start = 1'b1; tick(); b_start = 1'b0; tick(); tick();
    chk("wrap valid0", 32'(b_valid), 32'd1);
    chk("wrap pc15",   32'(b_pc),    32'hF);
    chk("wrap instr0", 32'(b_instr), 32'h0253);
    b_ack = 1'b1; tick(); b_ack = 1'b0;
    chk("wrap pc0",   32'(b_pc),       32'h0);
    chk("wrap addr0", 32'(b_mem_addr), 32'h0);
    tick(); tick();
    chk("wrap valid1", 32'(b_valid), 32'd1);
    chk("wrap instr1", 32'(b_instr), 32'h0291);
    b_ack = 1'b1; tick(); b_ack = 1'b0; tick(); tick();
    chk("wrap halt",    32'(b_halted), 32'd1);
    chk("wrap halt pc", 32'(b_pc),     32'h1);

    // ---- table-driven ack/redirect vectors ----
    a_rst = 1'b1; tick(); a_rst = 1'b0;
    for (int i = 0; i < 256; i++) mem_a[i] = 16'hA500 | 16'(i);
    mem_a[8'h20] = 16'h0000;
    a_start = 1'b1;
    wait_valid(1'b0, 1'b0, n);
    chk("tbl start lat",   32'(n),       32'd3);
    chk("tbl start instr", 32'(a_instr), 32'hA500);
    for (int i = 0; i < 6; i++) begin
      a_ack = 1'b1; a_redir = tbl[i].redir; a_rpc = tbl[i].target;
      wait_valid(1'b0, 1'b0, n);
      chk("tbl latency", 32'(n),        32'd3);
      chk("tbl pc",      32'(a_pc),     32'(tbl[i].exp_pc));
      chk("tbl instr",   32'(a_instr),  32'(tbl[i].exp_instr));
      chk("tbl halted",  32'(a_halted), 32'(tbl[i].exp_halt));
      chk("tbl valid",   32'(a_valid),  32'(!tbl[i].exp_halt));
    end

    // ---- randomized run against a transaction-level program model ----
    a_rst = 1'b1; tick(); a_rst = 1'b0;
    last_w = 16'h0000;
    fill_random();
    a_start = 1'b1;
    wait_valid(1'b0, 1'b1, n);
    exp_pc = 8'h00;
    for (int t = 0; t < 120; t++) begin
      w = mem_a[exp_pc];
      chk("rnd latency", 32'(n),    32'd3);
      chk("rnd pc",      32'(a_pc), 32'(exp_pc));
      if (w == 16'h0000) begin
        chk("rnd halted",     32'(a_halted), 32'd1);
        chk("rnd halt valid", 32'(a_valid),  32'd0);
        chk("rnd halt instr", 32'(a_instr),  32'(last_w));
        fill_random();
        a_ack = 1'b0; a_start = 1'b1;
        wait_valid(1'b0, 1'b1, n);
        exp_pc = 8'h00;
      end else begin
        chk("rnd valid",  32'(a_valid),  32'd1);
        chk("rnd halted0", 32'(a_halted), 32'd0);
        chk("rnd instr",  32'(a_instr),  32'(w));
        last_w = w;
        d = int'($urandom % 4);
        if (d > 0) begin
          a_ack = 1'b0;
          for (int j = 0; j < d; j++) begin
            a_start = 1'($urandom); a_redir = 1'($urandom); a_rpc = 8'($urandom);
            tick();
            chk("rnd hold instr", 32'(a_instr), 32'(w));
            chk("rnd hold pc",    32'(a_pc),    32'(exp_pc));
            chk("rnd hold valid", 32'(a_valid), 32'd1);
          end
        end
        r   = 1'($urandom);
        tgt = 8'($urandom);
        a_start = 1'($urandom);
        a_ack = 1'b1; a_redir = r; a_rpc = tgt;
        exp_pc = r ? tgt : exp_pc + 8'd1;
        wait_valid(1'($urandom), 1'b1, n);
      end
    end
    a_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
